add_chain_pipe: RTL and testbench

//   Synthesizable 3-stage registered add chain with valid/ready handshakes.
//   For each accepted operand x it produces 2x, 3x and 4x, one stage each,

---
 rtl/add_chain_pipe.sv | 118 +++++++++++
 tb/tb_add_chain_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_chain_pipe.sv
// add_chain_pipe: 3-stage registered add chain (2x, 3x, 4x) with
// valid/ready on both sides and a delivered-result counter.
module add_chain_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_d1,
  output logic [W-1:0]     out_d2,
  output logic [W-1:0]     out_d3,
  output logic [CNT_W-1:0] out_count
);

  logic             v1_q, v2_q, v3_q;
  logic             v1_d, v2_d, v3_d;
  logic [W-1:0]     x1_q, s1_1_q;
  logic [W-1:0]     x1_d, s1_1_d;
  logic [W-1:0]     x2_q, s1_2_q, s2_2_q;
  logic [W-1:0]     x2_d, s1_2_d, s2_2_d;
  logic [W-1:0]     s1_3_q, s2_3_q, s3_3_q;
  logic [W-1:0]     s1_3_d, s2_3_d, s3_3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mv1, mv2, mv3;
  logic ld1, ld2, ld3;
  logic acc;

  // Ready chain runs from the output back to the input so a full
  // pipe can drain and refill in the same cycle without a bubble.
  always_comb begin
    mv3 = v3_q & out_ready;
    ld3 = ~v3_q | mv3;
    mv2 = v2_q & ld3;
    ld2 = ~v2_q | mv2;
    mv1 = v1_q & ld2;
    ld1 = ~v1_q | mv1;
    acc = in_valid & ld1;
  end

  // Next-state: each stage loads when empty or when its contents leave.
  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    x1_d   = x1_q;
    s1_1_d = s1_1_q;
    x2_d   = x2_q;
    s1_2_d = s1_2_q;
    s2_2_d = s2_2_q;
    s1_3_d = s1_3_q;
    s2_3_d = s2_3_q;
    s3_3_d = s3_3_q;
    cnt_d  = cnt_q;
    if (ld1) v1_d = in_valid;
    if (acc) begin
      x1_d   = in_data;
      s1_1_d = in_data + in_data;
    end
    if (ld2) v2_d = v1_q;
    if (mv1) begin
      x2_d   = x1_q;
      s1_2_d = s1_1_q;
      s2_2_d = s1_1_q + x1_q;
    end
    if (ld3) v3_d = v2_q;
    if (mv2) begin
      s1_3_d = s1_2_q;
      s2_3_d = s2_2_q;
      s3_3_d = s2_2_q + x2_q;
    end
    if (mv3) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      x1_q   <= '0;
      s1_1_q <= '0;
      x2_q   <= '0;
      s1_2_q <= '0;
      s2_2_q <= '0;
      s1_3_q <= '0;
      s2_3_q <= '0;
      s3_3_q <= '0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      x1_q   <= x1_d;
      s1_1_q <= s1_1_d;
      x2_q   <= x2_d;
      s1_2_q <= s1_2_d;
      s2_2_q <= s2_2_d;
      s1_3_q <= s1_3_d;
      s2_3_q <= s2_3_d;
      s3_3_q <= s3_3_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign out_d1    = s1_3_q;
  assign out_d2    = s2_3_q;
  assign out_d3    = s3_3_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_add_chain_pipe.sv
// tb_add_chain_pipe: scoreboard bench for add_chain_pipe, plus a
// CNT_W=4 instance sharing the same stimulus for counter wrap.
module tb_add_chain_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic        in_ready, out_valid;
  logic [7:0]  d1, d2, d3;
  logic [15:0] cnt;
  logic        in_ready4, out_valid4;
  logic [7:0]  e1, e2, e3;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;
  logic [23:0] q[$];
  logic [23:0] sb_exp;

  add_chain_pipe #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d1(d1), .out_d2(d2), .out_d3(d3), .out_count(cnt)
  );

  add_chain_pipe #(.W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_d1(e1), .out_d2(e2), .out_d3(e3), .out_count(cnt4)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [7:0] x);
    int xi;
    logic [7:0] a, b, c;
    xi = int'(x);
    a = 8'((xi * 2) % 256);
    b = 8'((xi * 3) % 256);
    c = 8'((xi * 4) % 256);
    return {a, b, c};
  endfunction

  // Scoreboard: handshakes resolved on the coming posedge are judged
  // at the negedge, when inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected got %0d/%0d/%0d, none expected",
                   d1, d2, d3);
        end else begin
          sb_exp = q.pop_front();
          if ({d1, d2, d3} !== sb_exp) begin
            fails++;
            $display("FAIL sb_data got %0d/%0d/%0d want %0d/%0d/%0d",
                     d1, d2, d3, sb_exp[23:16], sb_exp[15:8], sb_exp[7:0]);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (q.size() != 0 || out_valid); i++) tick();
    tests++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b want 0/0",
               q.size(), out_valid);
    end
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    tests++;
    if ({out_valid, d1, d2, d3, cnt} !== 41'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state got v=%b d=%0d/%0d/%0d cnt=%0d rdy=%b want 0/0/0/0/0/1",
               out_valid, d1, d2, d3, cnt, in_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd4;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hff;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early got out_valid=%b want 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || d1 !== 8'd8 || d2 !== 8'd12 || d3 !== 8'd16) begin
      fails++;
      $display("FAIL single_latency got v=%b %0d/%0d/%0d want 1 8/12/16",
               out_valid, d1, d2, d3);
    end
    tick();
    tests++;
    if (cnt !== 16'd1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_count got cnt=%0d v=%b want 1/0", cnt, out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd100;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b1 || d1 !== 8'd200 || d2 !== 8'd44 || d3 !== 8'd144) begin
      fails++;
      $display("FAIL overflow got v=%b %0d/%0d/%0d want 1 200/44/144",
               out_valid, d1, d2, d3);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready beat %0d got %b want 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tests++;
      if (out_valid !== 1'b1 || d3 !== 8'(4 * i)) begin
        fails++;
        $display("FAIL b2b_out beat %0d got v=%b d3=%0d want 1/%0d",
                 i, out_valid, d3, 4 * i);
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_tail got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL bp_accept x=%0d got in_ready=%b want 1", i, in_ready);
      end
      tick();
    end
    in_data = 8'd8;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          d1 !== 8'd10 || d2 !== 8'd15 || d3 !== 8'd20) begin
        fails++;
        $display("FAIL bp_hold cyc %0d got rdy=%b v=%b %0d/%0d/%0d want 0 1 10/15/20",
                 k, in_ready, out_valid, d1, d2, d3);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [15:0] c0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd9;
    tick();
    in_data = 8'd10;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    q.delete();
    #1;
    tests++;
    if (out_valid !== 1'b0 || cnt !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_async got v=%b cnt=%0d want 0/0", out_valid, cnt);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_ghost cyc %0d got out_valid=%b want 0", i, out_valid);
      end
      tick();
    end
    c0 = cnt;
    in_valid = 1'b1;
    in_data  = 8'd4;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (c0 !== 16'd0 || out_valid !== 1'b1 ||
        d1 !== 8'd8 || d2 !== 8'd12 || d3 !== 8'd16) begin
      fails++;
      $display("FAIL rstmid_fresh got cnt0=%0d v=%b %0d/%0d/%0d want 0 1 8/12/16",
               c0, out_valid, d1, d2, d3);
    end
    drain();
  endtask

  task automatic test_random_stall();
    int acc = 0;
    for (int c = 0; c < 600 && acc < 40; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      #1;
      if (in_valid && in_ready) acc++;
      tick();
    end
    tests++;
    if (acc < 40) begin
      fails++;
      $display("FAIL rand_progress got %0d accepted want 40", acc);
    end
    drain();
  endtask

  task automatic test_count_wrap();
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i * 7);
      tick();
    end
    drain();
    tests++;
    if (cnt4 !== 4'd1 || cnt !== 16'd17) begin
      fails++;
      $display("FAIL count_wrap got cnt4=%0d cnt=%0d want 1/17", cnt4, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random_stall();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
